// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencer: runs a req/ack handshake to data memory for loads and
// stores, stalls the front of the pipeline, and bubbles the M->W register meanwhile.
module mem_stage_ctrl #(
  parameter int N       = 32,
  parameter int MAXWAIT = 16,
  parameter int CW      = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         memread_M,
  input  logic         memwrite_M,
  input  logic [N-1:0] addr_M,
  input  logic [N-1:0] wdata_M,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata,
  output logic [N-1:0] readdata_M,
  output logic         stall,
  output logic         bubble_W,
  output logic         mem_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [CW-1:0] LAST_WAIT = CW'(MAXWAIT - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [N-1:0]  r_mem_addr;
  logic [N-1:0]  r_mem_wdata;
  logic [N-1:0]  r_readdata;
  logic          r_mem_err;
  logic          w_access;
  logic          w_stall;

  assign w_access = memread_M | memwrite_M;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_readdata  <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            r_mem_addr  <= addr_M;
            r_mem_wdata <= wdata_M;
            r_mem_we    <= memwrite_M;
            r_mem_req   <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // An ack on the last allowed cycle completes normally, never a timeout.
          if (mem_ack) begin
            r_readdata <= r_mem_we ? '0 : mem_rdata;
            r_mem_req  <= 1'b0;
            r_state    <= S_DONE;
          end else if (r_cnt == LAST_WAIT) begin
            r_readdata <= '0;
            r_mem_err  <= 1'b1;
            r_mem_req  <= 1'b0;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          // Same instruction is still in M this cycle, so access_M is ignored.
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_stall = (r_state == S_ACCESS) || ((r_state == S_IDLE) && w_access);

  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign readdata_M = r_readdata;
  assign mem_err    = r_mem_err;
  assign stall      = w_stall;
  assign bubble_W   = w_stall;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: a transaction-level model compared
// every cycle, plus directed transactions with hand-computed expectations.
module tb_mem_stage_ctrl;

  localparam int N       = 32;
  localparam int MAXWAIT = 16;
  localparam int CW      = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         memread_M = 1'b0;
  logic         memwrite_M = 1'b0;
  logic [N-1:0] addr_M = '0;
  logic [N-1:0] wdata_M = '0;
  logic         mem_req;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic         mem_ack = 1'b0;
  logic [N-1:0] mem_rdata = '0;
  logic [N-1:0] readdata_M;
  logic         stall;
  logic         bubble_W;
  logic         mem_err;

  int n_checks = 0;
  int n_errors = 0;
  int stall_cnt = 0;
  int req_cnt = 0;

  mem_stage_ctrl #(.N(N), .MAXWAIT(MAXWAIT), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .memread_M  (memread_M),
    .memwrite_M (memwrite_M),
    .addr_M     (addr_M),
    .wdata_M    (wdata_M),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .readdata_M (readdata_M),
    .stall      (stall),
    .bubble_W   (bubble_W),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: one outstanding access, how many cycles it has
  // waited, and whether the finished instruction is in its hand-off cycle.
  bit           m_busy, m_handoff, m_we, m_err;
  int           m_waited;
  logic [N-1:0] m_addr, m_wdata, m_rd;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_handoff = 0; m_we = 0; m_err = 0; m_waited = 0;
      m_addr = '0; m_wdata = '0; m_rd = '0;
    end else if (m_handoff) begin
      m_handoff = 0;
    end else if (m_busy) begin
      if (mem_ack) begin
        m_rd = m_we ? '0 : mem_rdata;
        m_busy = 0; m_handoff = 1;
      end else if (m_waited + 1 == MAXWAIT) begin
        m_rd = '0; m_err = 1;
        m_busy = 0; m_handoff = 1;
      end else begin
        m_waited++;
      end
    end else if (memread_M || memwrite_M) begin
      m_addr = addr_M; m_wdata = wdata_M; m_we = memwrite_M;
      m_busy = 1; m_waited = 0;
    end
  end

  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = m_busy || (!m_handoff && (memread_M || memwrite_M));
    check("mem_req", 32'(mem_req), 32'(m_busy));
    check("stall", 32'(stall), 32'(exp_stall));
    check("bubble_W", 32'(bubble_W), 32'(exp_stall));
    check("mem_err", 32'(mem_err), 32'(m_err));
    check("readdata_M", readdata_M, m_rd);
    if (m_busy) begin
      check("mem_we", 32'(mem_we), 32'(m_we));
      check("mem_addr", mem_addr, m_addr);
      check("mem_wdata", mem_wdata, m_wdata);
    end
    if (stall) stall_cnt++;
    if (mem_req) req_cnt++;
  end

  // Issue one memory instruction; k = ACCESS cycles before ack, k<0 = never ack.
  task automatic do_mem(input bit rd, input bit wr, input logic [N-1:0] a,
                        input logic [N-1:0] wd, input int k, input logic [N-1:0] rdv,
                        input logic [N-1:0] exp_rd, input int exp_stalls,
                        input int exp_reqs, input string tag);
    memread_M = rd; memwrite_M = wr; addr_M = a; wdata_M = wd;
    stall_cnt = 0; req_cnt = 0;
    @(posedge clk); #1;
    check({tag, " addr"}, mem_addr, a);
    check({tag, " we"}, 32'(mem_we), 32'(wr));
    for (int cyc = 0; cyc < MAXWAIT; cyc++) begin
      if (cyc == k) begin mem_ack = 1'b1; mem_rdata = rdv; end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (cyc == k) break;
    end
    @(negedge clk);
    check({tag, " result"}, readdata_M, exp_rd);
    check({tag, " done stall"}, 32'(stall), 32'd0);
    @(posedge clk); #1;
    check({tag, " stall cycles"}, 32'(stall_cnt), 32'(exp_stalls));
    check({tag, " req cycles"}, 32'(req_cnt), 32'(exp_reqs));
  endtask

  task automatic idle_cycle();
    memread_M = 1'b0; memwrite_M = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset with a load pending in M: registers clear, stall follows access_M.
    #1 rst = 1'b0;
    memread_M = 1'b1; addr_M = 32'h40;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst readdata", readdata_M, 32'd0);
    check("rst stall", 32'(stall), 32'd1);
    @(posedge clk); #1 rst = 1'b1;

    // Load at 0x40 released from reset, ack immediately.
    do_mem(1, 0, 32'h40, 32'h0, 0, 32'hCAFE0001, 32'hCAFE0001, 2, 1, "post-reset load");
    idle_cycle();

    // Read, immediate ack.
    do_mem(1, 0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 2, 1, "read k0");
    idle_cycle();
    check("nonmem holds readdata", readdata_M, 32'hDEADBEEF);

    // Write with 3 wait cycles: ack on the 4th ACCESS cycle.
    do_mem(0, 1, 32'h2004, 32'h12345678, 3, 32'hFFFFFFFF, 32'h0, 5, 4, "write k3");
    idle_cycle();

    // Both strobes set: treated as a store.
    do_mem(1, 1, 32'h88, 32'hA5A5A5A5, 1, 32'h55555555, 32'h0, 3, 2, "read+write");
    idle_cycle();

    // Back-to-back loads with no gap instruction in between.
    do_mem(1, 0, 32'h10, 32'h0, 0, 32'h11111111, 32'h11111111, 2, 1, "b2b first");
    do_mem(1, 0, 32'h14, 32'h0, 0, 32'h22222222, 32'h22222222, 2, 1, "b2b second");
    idle_cycle();

    // Ack on the final allowed cycle: completes without error.
    do_mem(1, 0, 32'h200, 32'h0, MAXWAIT - 1, 32'h0BADF00D, 32'h0BADF00D,
           MAXWAIT + 1, MAXWAIT, "last-cycle ack");
    check("no err on last-cycle ack", 32'(mem_err), 32'd0);
    idle_cycle();

    // Timeout: no ack at all.
    do_mem(1, 0, 32'h300, 32'h0, -1, 32'h0, 32'h0, MAXWAIT + 1, MAXWAIT, "timeout");
    check("err set by timeout", 32'(mem_err), 32'd1);
    idle_cycle();
    do_mem(1, 0, 32'h304, 32'h0, 0, 32'h76543210, 32'h76543210, 2, 1, "load after err");
    check("err sticky", 32'(mem_err), 32'd1);
    idle_cycle();

    // Async reset two cycles into a wait, then a stray ack in IDLE.
    memread_M = 1'b1; addr_M = 32'h400;
    repeat (3) begin @(posedge clk); #1; end
    check("pre-reset req", 32'(mem_req), 32'd1);
    #2;
    rst = 1'b0; memread_M = 1'b0;
    #1;
    check("async rst req", 32'(mem_req), 32'd0);
    check("async rst stall", 32'(stall), 32'd0);
    check("async rst addr", mem_addr, 32'd0);
    check("async rst err", 32'(mem_err), 32'd0);
    check("async rst we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("stray ack req", 32'(mem_req), 32'd0);
    check("stray ack readdata", readdata_M, 32'd0);
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
